// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ requesters.
// One blocking transaction is outstanding at a time; completion waits for the memory response.
module core_mem_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*ADDR_W-1:0]      req_addr,
  input  logic [N_REQ-1:0]             req_we,
  input  logic [N_REQ*DATA_W-1:0]      req_wdata,
  input  logic [N_REQ*(DATA_W/8)-1:0]  req_wstrb,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wstrb,
  input  logic                         mem_rsp_valid,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rsp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             grant;
  logic             complete;
  int               cand;

  // Search downward from the farthest offset so the nearest request at or after rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant = (state == IDLE) && pick_found;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    mem_valid  = 1'b0;
    unique case (state)
      IDLE: if (pick_found) state_next = ADDR;
      ADDR: begin
        mem_valid = 1'b1;
        if (mem_ready && mem_rsp_valid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (mem_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (mem_rsp_valid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (complete) req_ready[grant_idx] = 1'b1;
  end

  // Response data is a pure pass-through; it is only meaningful alongside a req_ready bit.
  assign rsp_rdata = mem_rdata;
  assign rsp_err   = mem_rsp_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        grant_idx <= pick_idx;
        mem_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        mem_we    <= req_we[pick_idx];
        mem_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        mem_wstrb <= req_wstrb[int'(pick_idx)*STRB_W +: STRB_W];
      end
      if (complete) begin
        rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a 2-requester instance for most scenarios
// and a 3-requester instance for round-robin pointer wrap.
module tb_core_mem_arbiter;

  logic        clk;
  logic        rst_n;

  logic [1:0]  req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid, mem_ready, mem_we, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic [2:0]  t3_req_valid, t3_req_ready, t3_req_we;
  logic [95:0] t3_req_addr, t3_req_wdata;
  logic [11:0] t3_req_wstrb;
  logic [31:0] t3_rsp_rdata;
  logic        t3_rsp_err;
  logic        t3_mem_valid, t3_mem_ready, t3_mem_we, t3_mem_rsp_valid, t3_mem_rsp_err;
  logic [31:0] t3_mem_addr, t3_mem_wdata, t3_mem_rdata;
  logic [3:0]  t3_mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  core_mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
  );

  core_mem_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(t3_req_valid), .req_ready(t3_req_ready), .req_addr(t3_req_addr),
    .req_we(t3_req_we), .req_wdata(t3_req_wdata), .req_wstrb(t3_req_wstrb),
    .rsp_rdata(t3_rsp_rdata), .rsp_err(t3_rsp_err),
    .mem_valid(t3_mem_valid), .mem_ready(t3_mem_ready), .mem_addr(t3_mem_addr),
    .mem_we(t3_mem_we), .mem_wdata(t3_mem_wdata), .mem_wstrb(t3_mem_wstrb),
    .mem_rsp_valid(t3_mem_rsp_valid), .mem_rdata(t3_mem_rdata), .mem_rsp_err(t3_mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
    t3_req_valid = '0; t3_req_we = '0; t3_req_addr = '0; t3_req_wdata = '0; t3_req_wstrb = '0;
    t3_mem_ready = 1'b0; t3_mem_rsp_valid = 1'b0; t3_mem_rdata = '0; t3_mem_rsp_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_rdata   = 32'h1234_5678;
    mem_rsp_err = 1'b1;
    req_valid   = 2'b01;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b exp 0", mem_valid); end
    n_tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_payload: addr %h wdata %h exp 0", mem_addr, mem_wdata); end
    n_tests++; if (mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_we_strb: we %b strb %b exp 0", mem_we, mem_wstrb); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
    n_tests++; if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL reset_passthru: rdata %h err %b exp 12345678 1", rsp_rdata, rsp_err); end
    step();
    rst_n = 1'b1;
    req_valid = 2'b00;
    mem_rsp_valid = 1'b1;
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_rsp_ignored: got %b exp 00", req_ready); end
    step();
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL idle_stays_idle: mem_valid %b exp 0", mem_valid); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_valid = 2'b01;
    req_addr[31:0] = 32'h100;
    #1;
    n_tests++; if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL read_c0: mem_valid %b req_ready %b exp 0 00", mem_valid, req_ready); end
    step();
    mem_ready = 1'b1;
    #1;
    n_tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || req_ready !== 2'b00) begin n_fail++; $display("FAIL read_c1: mem_valid %b addr %h req_ready %b exp 1 100 00", mem_valid, mem_addr, req_ready); end
    step();
    mem_ready = 1'b0;
    #1;
    n_tests++; if (mem_valid !== 1'b0 || mem_addr !== 32'h100 || req_ready !== 2'b00) begin n_fail++; $display("FAIL read_c2: mem_valid %b addr %h req_ready %b exp 0 100 00", mem_valid, mem_addr, req_ready); end
    step();
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (req_ready !== 2'b01 || rsp_rdata !== 32'hDEAD_BEEF || mem_addr !== 32'h100) begin n_fail++; $display("FAIL read_c3: req_ready %b rdata %h addr %h exp 01 deadbeef 100", req_ready, rsp_rdata, mem_addr); end
    step();
    req_valid = 2'b00;
    mem_rsp_valid = 1'b0;
    #1;
    n_tests++; if (req_ready !== 2'b00 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL read_c4: req_ready %b mem_valid %b exp 00 0", req_ready, mem_valid); end
  endtask

  task automatic test_fairness();
    logic [31:0] exp_addr;
    logic [1:0]  exp_ready;
    do_reset();
    req_addr = {32'h2000, 32'h1000};
    req_valid = 2'b11;
    mem_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      n_tests++; if (req_ready !== 2'b00 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL fair_idle t%0d: req_ready %b mem_valid %b exp 00 0", t, req_ready, mem_valid); end
      step();
      exp_addr  = (t % 2 == 1) ? 32'h2000 : 32'h1000;
      exp_ready = (t % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      n_tests++; if (mem_valid !== 1'b1 || mem_addr !== exp_addr || req_ready !== exp_ready) begin n_fail++; $display("FAIL fair_xfer t%0d: mem_valid %b addr %h req_ready %b exp 1 %h %b", t, mem_valid, mem_addr, req_ready, exp_addr, exp_ready); end
      step();
    end
  endtask

  task automatic test_stalls();
    do_reset();
    req_valid = 2'b01;
    req_addr[31:0] = 32'h200;
    req_wdata[31:0] = 32'h55;
    req_wstrb[3:0] = 4'hF;
    step();
    for (int c = 1; c <= 3; c++) begin
      mem_ready = 1'b0;
      mem_rsp_valid = (c == 2);
      req_addr[31:0] = 32'hBAD0;
      req_wdata[31:0] = 32'hBAD1;
      req_valid = (c >= 2) ? 2'b00 : 2'b01;
      #1;
      n_tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h55 || req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_c%0d: mem_valid %b addr %h wdata %h req_ready %b exp 1 200 55 00", c, mem_valid, mem_addr, mem_wdata, req_ready); end
      step();
    end
    mem_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    n_tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200 || req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_accept: mem_valid %b addr %h req_ready %b exp 1 200 00", mem_valid, mem_addr, req_ready); end
    step();
    mem_ready = 1'b0;
    #1;
    n_tests++; if (mem_valid !== 1'b0 || mem_addr !== 32'h200 || req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_wait: mem_valid %b addr %h req_ready %b exp 0 200 00", mem_valid, mem_addr, req_ready); end
    step();
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h600D_F00D;
    #1;
    n_tests++; if (req_ready !== 2'b01 || rsp_rdata !== 32'h600D_F00D) begin n_fail++; $display("FAIL stall_done: req_ready %b rdata %h exp 01 600df00d", req_ready, rsp_rdata); end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_tests++; if (req_ready !== 2'b00 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL stall_after: req_ready %b mem_valid %b exp 00 0", req_ready, mem_valid); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_valid = 2'b01;
    req_addr = {32'h20, 32'h10};
    step();
    mem_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    step();
    req_valid = 2'b10;
    mem_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    step();
    mem_ready = 1'b1;
    #1;
    n_tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h20) begin n_fail++; $display("FAIL rst_pre_addr: mem_valid %b addr %h exp 1 20", mem_valid, mem_addr); end
    step();
    mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    mem_rsp_valid = 1'b1;
    #1;
    n_tests++; if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_abort: mem_valid %b addr %h we %b req_ready %b exp 0 0 0 00", mem_valid, mem_addr, mem_we, req_ready); end
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b0;
    req_valid = 2'b11;
    req_addr = {32'h40, 32'h30};
    #1;
    n_tests++; if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_release: mem_valid %b req_ready %b exp 0 00", mem_valid, req_ready); end
    step();
    n_tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h30) begin n_fail++; $display("FAIL rst_first_grant: mem_valid %b addr %h exp 1 30", mem_valid, mem_addr); end
  endtask

  task automatic test_write_err();
    do_reset();
    req_valid = 2'b10;
    req_we = 2'b10;
    req_addr[63:32] = 32'h300;
    req_wdata[63:32] = 32'hCAFE_F00D;
    req_wstrb[7:4] = 4'b0011;
    step();
    mem_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_err = 1'b1;
    #1;
    n_tests++; if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h300) begin n_fail++; $display("FAIL wr_payload: valid %b we %b strb %b wdata %h addr %h exp 1 1 0011 cafef00d 300", mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr); end
    n_tests++; if (req_ready !== 2'b10 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL wr_done: req_ready %b err %b exp 10 1", req_ready, rsp_err); end
    step();
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr[31:0] = 32'h400;
    mem_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err = 1'b0;
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL wr_idle: req_ready %b exp 00", req_ready); end
    step();
    n_tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_ptr_wrap: valid %b addr %h we %b exp 1 400 0", mem_valid, mem_addr, mem_we); end
  endtask

  task automatic test_wrap3();
    do_reset();
    t3_req_addr = {32'hA2, 32'hA1, 32'hA0};
    t3_req_valid = 3'b010;
    step();
    t3_mem_ready = 1'b1;
    t3_mem_rsp_valid = 1'b1;
    #1;
    n_tests++; if (t3_req_ready !== 3'b010 || t3_mem_addr !== 32'hA1) begin n_fail++; $display("FAIL wrap_first: req_ready %b addr %h exp 010 a1", t3_req_ready, t3_mem_addr); end
    step();
    t3_req_valid = 3'b011;
    t3_mem_ready = 1'b0;
    t3_mem_rsp_valid = 1'b0;
    step();
    t3_mem_ready = 1'b1;
    t3_mem_rsp_valid = 1'b1;
    #1;
    n_tests++; if (t3_mem_valid !== 1'b1 || t3_mem_addr !== 32'hA0 || t3_req_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_grant0: valid %b addr %h req_ready %b exp 1 a0 001", t3_mem_valid, t3_mem_addr, t3_req_ready); end
    step();
    t3_req_valid = 3'b110;
    t3_mem_ready = 1'b0;
    t3_mem_rsp_valid = 1'b0;
    step();
    #1;
    n_tests++; if (t3_mem_valid !== 1'b1 || t3_mem_addr !== 32'hA1) begin n_fail++; $display("FAIL wrap_next1: valid %b addr %h exp 1 a1", t3_mem_valid, t3_mem_addr); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    test_reset();
    test_single_read();
    test_fairness();
    test_stalls();
    test_reset_mid_op();
    test_write_err();
    test_wrap3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Arbitrates one shared memory port between `N_REQ` requesters. In the multicycle core, requester 0 is the FETCH stage and requester 1 is the MEM stage; higher indices are spare for debug or DMA. Each requester sees one blocking transaction per valid/ready handshake, which completes when the memory response returns. Grants rotate round-robin so no requester starves.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters (≥2).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` strobe bits.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester request. Held high until the matching `req_ready`.
- `req_ready`  out  N_REQ  one-hot completion pulse. Read data and error are valid in the same cycle.
- `req_addr`  in  N_REQ*ADDR_W  packed addresses; requester i occupies `[i*ADDR_W +: ADDR_W]`.
- `req_we`  in  N_REQ  write enable.
- `req_wdata`  in  N_REQ*DATA_W  packed write data.
- `req_wstrb`  in  N_REQ*DATA_W/8  packed byte strobes.
- `rsp_rdata`  out  DATA_W  shared read data. Meaningful only with a `req_ready` bit.
- `rsp_err`  out  1  shared error flag. Meaningful only with a `req_ready` bit.
- `mem_valid`  out  1  downstream request valid.
- `mem_ready`  in  1  downstream accepts the request.
- `mem_addr`  out  ADDR_W  registered address.
- `mem_we`  out  1  registered write enable.
- `mem_wdata`  out  DATA_W  registered write data.
- `mem_wstrb`  out  DATA_W/8  registered byte strobes.
- `mem_rsp_valid`  in  1  downstream response valid, single-cycle pulse.
- `mem_rdata`  in  DATA_W  downstream read data.
- `mem_rsp_err`  in  1  downstream access error.

## Operation
State machine has three states: IDLE, ADDR, RESP.
- **IDLE:** if any `req_valid`, select the first set bit at or after `rr_ptr`, searching upward with wrap. Latch `grant_idx` and capture that requester's addr/we/wdata/wstrb into payload registers. Next state is ADDR. If no request, stay in IDLE.
- **ADDR:** `mem_valid`=1.
  - `mem_ready` & `mem_rsp_valid` → complete, next state IDLE.
  - `mem_ready` only → next state RESP.
  - otherwise stay in ADDR.
- **RESP:** `mem_valid`=0. `mem_rsp_valid` → complete, next state IDLE; otherwise stay in RESP.
- **Complete:**
  - `req_ready[grant_idx]`=1 for that cycle only.
  - `rsp_rdata`=`mem_rdata` and `rsp_err`=`mem_rsp_err`, passed through combinationally.
  - `rr_ptr` ← (`grant_idx`+1) mod `N_REQ`.
- `mem_rsp_valid` in IDLE is ignored. `mem_rsp_valid` in ADDR without `mem_ready` is ignored.
- Payload is frozen from grant to completion; requester input changes after grant have no effect.
- A requester that drops `req_valid` mid-transaction does not abort it. The transaction still completes and the `req_ready` pulse is still issued.
- Reads and writes follow the identical flow. Write completion also waits for `mem_rsp_valid`.
- Only one transaction is outstanding at any time.
- `rr_ptr` wraps from `N_REQ`-1 to 0.

## Timing
- **Reset values:** state=IDLE, `grant_idx`=0, `rr_ptr`=0, payload registers=0. Hence `mem_valid`=0, `mem_addr`/`mem_wdata`/`mem_wstrb`=0, `mem_we`=0, `req_ready`=0.
- `rsp_rdata`/`rsp_err` follow `mem_rdata`/`mem_rsp_err` combinationally at all times, including during reset.
- `rst_n` low mid-transaction aborts immediately to the reset values. No `req_ready` is issued for the aborted transaction.
- **Minimum latency:** `req_valid` high in IDLE at cycle 0 → `mem_valid` high in cycle 1. With `mem_ready` and `mem_rsp_valid` both high in cycle 1, `req_ready` pulses in cycle 1.
- **Back-to-back:** one IDLE cycle always separates transactions, so the maximum rate is one transaction per 2 cycles.
- `req_ready` depends combinationally on `mem_ready`/`mem_rsp_valid` and the registered state. There is no combinational path from `req_valid` to any output.

## Test plan
- **Single read:** `req_valid`=01, addr0=0x100; memory gives `mem_ready` in cycle 1 and `mem_rsp_valid` in cycle 3 with rdata 0xDEADBEEF. Required: `mem_addr`=0x100 in cycles 1–3; `mem_valid` high in cycle 1 only; `req_ready`=01 in cycle 3 with `rsp_rdata`=0xDEADBEEF.
- **Fairness:** both requesters hold `req_valid` for 4 transactions with zero-wait memory. Required: grant order 0,1,0,1; each transaction takes 2 cycles; `req_ready` alternates 01/10.
- **Stalls:** `mem_ready` withheld for 3 cycles, then response 2 cycles after accept. Required: `mem_valid` held for 4 cycles; payload stable throughout; one `req_ready` pulse at the response.
- **Wrap:** with `N_REQ`=3, `rr_ptr`=2 and requests from 0 and 1. Required: requester 0 is granted first.
- **Reset mid-op:** assert `rst_n` low during RESP. Required: all outputs return to their reset values asynchronously; no `req_ready`; after release the first grant goes to requester 0.
- **Write with error:** requester 1 writes wstrb=0011, and the response has `mem_rsp_err`=1. Required: `mem_we`=1 and `mem_wstrb`=0011; `req_ready`=10 with `rsp_err`=1; `rr_ptr`=0 afterwards.
